alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 178 +++++++++++++++++
 tb/tb_alu_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags and an iterative shift-add multiplier.
// Single-cycle ops complete in IDLE; MUL walks one multiplier bit per cycle in BUSY.
module alu_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] BusA,
  input  logic [N-1:0] BusB,
  input  logic [5:0]   OpCode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic         Zero,
  output logic         Neg,
  output logic         Carry,
  output logic         Ovf,
  output logic         Err
);
  localparam int S = $clog2(N);
  localparam logic [S-1:0] CNT_LAST = S'(N - 1);

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SLT = 6'b101010;
  localparam logic [5:0] OP_MUL = 6'b011000;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [N-1:0] res;
    logic         zero;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         err;
  } res_t;

  function automatic res_t alu_eval(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic [5:0] op);
    res_t                r;
    logic [N:0]          sum;
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    logic [S-1:0]        amt;
    r   = '0;
    sum = '0;
    sa  = $signed(a);
    sb  = $signed(b);
    amt = b[S-1:0];
    case (op)
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b};
        r.res   = sum[N-1:0];
        r.carry = sum[N];
        r.ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        // Top bit of the zero-extended difference is the borrow.
        sum     = {1'b0, a} - {1'b0, b};
        r.res   = sum[N-1:0];
        r.carry = ~sum[N];
        r.ovf   = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_AND:  r.res = a & b;
      OP_OR:   r.res = a | b;
      OP_XOR:  r.res = a ^ b;
      OP_NOR:  r.res = ~(a | b);
      OP_SLL:  r.res = a << amt;
      OP_SRL:  r.res = a >> amt;
      OP_SRA:  r.res = $unsigned(sa >>> amt);
      OP_SLT:  r.res = {{(N-1){1'b0}}, (sa < sb)};
      OP_MUL:  r.res = '0;
      default: begin
        r.res = '1;
        r.err = 1'b1;
      end
    endcase
    if (!r.err) begin
      r.zero = (r.res == '0);
      r.neg  = r.res[N-1];
    end
    return r;
  endfunction

  function automatic res_t mul_eval(input logic [2*N-1:0] prod);
    res_t r;
    r      = '0;
    r.res  = prod[N-1:0];
    r.zero = (prod[N-1:0] == '0);
    r.neg  = prod[N-1];
    r.ovf  = (prod[2*N-1:N] != '0);
    return r;
  endfunction

  state_t         state;
  logic [S-1:0]   cnt;
  logic [2*N-1:0] mcand_p0;
  logic [2*N-1:0] acc_p0;
  logic [2*N-1:0] acc_nx_p0;
  logic [N-1:0]   mplier_p0;
  res_t           ev_p0;
  res_t           mul_p0;
  res_t           out_p1;
  logic           accept;
  logic           is_mul;

  assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (OpCode == OP_MUL);

  always_comb begin
    acc_nx_p0 = acc_p0 + (mplier_p0[cnt] ? (mcand_p0 << cnt) : '0);
    ev_p0     = alu_eval(BusA, BusB, OpCode);
    mul_p0    = mul_eval(acc_nx_p0);
  end

  // Multiplier datapath: no reset needed, every MUL starts by reloading it.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand_p0  <= {{N{1'b0}}, BusA};
      mplier_p0 <= BusB;
      acc_p0    <= '0;
    end else if (state == BUSY) begin
      acc_p0 <= acc_nx_p0;
    end
  end

  // Control and output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_p1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state     <= BUSY;
            cnt       <= '0;
            out_valid <= 1'b0;
          end else if (accept) begin
            out_p1    <= ev_p0;
            out_valid <= 1'b1;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            out_p1    <= mul_p0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Result = out_p1.res;
  assign Zero   = out_p1.zero;
  assign Neg    = out_p1.neg;
  assign Carry  = out_p1.carry;
  assign Ovf    = out_p1.ovf;
  assign Err    = out_p1.err;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (N=8): directed scenarios plus randomized ops.
module tb_alu_pipe;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] BusA;
  logic [N-1:0] BusB;
  logic [5:0]   OpCode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Result;
  logic         Zero, Neg, Carry, Ovf, Err;

  int total = 0;
  int bad   = 0;
  logic [N+4:0] sb[$];

  alu_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .BusA(BusA), .BusB(BusB), .OpCode(OpCode), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Zero(Zero), .Neg(Neg),
    .Carry(Carry), .Ovf(Ovf), .Err(Err)
  );

  always #5 clk = ~clk;

  // Reference model, written with integer arithmetic.
  function automatic logic [N+4:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    int ua, ub, sa, sb2, r;
    logic [7:0] res;
    logic z, ng, c, o, e;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb2 = int'($signed(b));
    c = 0; o = 0; e = 0; res = 8'h00;
    case (op)
      6'b100000: begin r = ua + ub; res = r[7:0]; c = (r > 255);
                       o = (sa + sb2 > 127) || (sa + sb2 < -128); end
      6'b100010: begin r = ua - ub; res = r[7:0]; c = (ua >= ub);
                       o = (sa - sb2 > 127) || (sa - sb2 < -128); end
      6'b100100: res = a & b;
      6'b100101: res = a | b;
      6'b100110: res = a ^ b;
      6'b100111: res = ~(a | b);
      6'b000000: begin r = ua << ub[2:0]; res = r[7:0]; end
      6'b000010: begin r = ua >> ub[2:0]; res = r[7:0]; end
      6'b000011: begin r = sa >>> ub[2:0]; res = r[7:0]; end
      6'b101010: res = (sa < sb2) ? 8'h01 : 8'h00;
      6'b011000: begin r = ua * ub; res = r[7:0]; o = (r > 255); end
      default:   begin res = 8'hFF; e = 1; end
    endcase
    z  = (res == 8'h00) && !e;
    ng = res[7] && !e;
    return {res, z, ng, c, o, e};
  endfunction

  // Scoreboard: every handshaken result is popped and compared.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [N+4:0] exp_v, got_v;
      got_v = {Result, Zero, Neg, Carry, Ovf, Err};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h required=none", got_v);
      end else begin
        exp_v = sb.pop_front();
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL scoreboard got={res=%h z%b n%b c%b o%b e%b} required={res=%h z%b n%b c%b o%b e%b}",
                   got_v[12:5], got_v[4], got_v[3], got_v[2], got_v[1], got_v[0],
                   exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // Presents one op and returns 1 time unit after the edge that accepted it.
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int n;
    BusA = a; BusB = b; OpCode = op; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL accept_timeout got=in_ready_low required=accept_within_50");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    BusA = '0; BusB = '0; OpCode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, Result, Zero, Neg, Carry, Ovf, Err} !== '0) begin
      bad++;
      $display("FAIL reset_state got=rdy%b vld%b res=%h flags=%b%b%b%b%b required=all_zero",
               in_ready, out_valid, Result, Zero, Neg, Carry, Ovf, Err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub_back_to_back;
    sb.push_back({8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    drive_op(8'h7F, 8'h01, 6'b100000);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL add_latency got=out_valid=%b required=1", out_valid);
    end
    sb.push_back({8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    drive_op(8'h05, 8'h05, 6'b100010);
    total++;
    if (out_valid !== 1'b1 || Result !== 8'h00) begin
      bad++;
      $display("FAIL sub_back_to_back got=vld%b res=%h required=vld1 res=00", out_valid, Result);
    end
    idle(2);
  endtask

  task automatic test_mul;
    logic [7:0] a_t[2] = '{8'd13, 8'd20};
    logic [7:0] b_t[2] = '{8'd11, 8'd20};
    logic [N+4:0] e_t[2] = '{{8'h8F, 5'b01000}, {8'h90, 5'b01010}};
    for (int t = 0; t < 2; t++) begin
      int busy_bad;
      sb.push_back(e_t[t]);
      drive_op(a_t[t], b_t[t], 6'b011000);
      busy_bad = 0;
      repeat (N) begin
        @(negedge clk);
        if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      end
      total++;
      if (busy_bad != 0) begin
        bad++;
        $display("FAIL mul_busy got=%0d_bad_cycles required=0", busy_bad);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL mul_latency got=out_valid=%b required=1_after_N_edges", out_valid);
      end
      @(posedge clk); #1;
      idle(1);
    end
  endtask

  task automatic test_shifts_slt;
    sb.push_back({8'hF0, 5'b01000});
    drive_op(8'h80, 8'h03, 6'b000011);
    sb.push_back({8'h10, 5'b00000});
    drive_op(8'h80, 8'h0B, 6'b000010);
    sb.push_back({8'h80, 5'b01000});
    drive_op(8'h01, 8'h07, 6'b000000);
    sb.push_back({8'h01, 5'b00000});
    drive_op(8'hFF, 8'h01, 6'b101010);
    idle(2);
  endtask

  task automatic test_backpressure;
    int stall_bad;
    out_ready = 1'b0;
    sb.push_back({8'h46, 5'b00000});
    drive_op(8'h12, 8'h34, 6'b100000);
    stall_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (Result !== 8'h46 || in_ready !== 1'b0 || out_valid !== 1'b1) stall_bad++;
      @(posedge clk); #1;
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL backpressure_hold got=%0d_bad_cycles required=0", stall_bad);
    end
    out_ready = 1'b1;
    sb.push_back({8'hFF, 5'b01000});
    drive_op(8'hF0, 8'h0F, 6'b100110);
    total++;
    if (out_valid !== 1'b1 || Result !== 8'hFF) begin
      bad++;
      $display("FAIL consume_and_load got=vld%b res=%h required=vld1 res=ff", out_valid, Result);
    end
    idle(2);
  endtask

  task automatic test_invalid_opcode;
    sb.push_back({8'hFF, 5'b00001});
    drive_op(8'h12, 8'h34, 6'b111111);
    total++;
    if (Err !== 1'b1 || Result !== 8'hFF) begin
      bad++;
      $display("FAIL invalid_op got=err%b res=%h required=err1 res=ff", Err, Result);
    end
    sb.push_back({8'h02, 5'b00000});
    drive_op(8'h01, 8'h01, 6'b100000);
    total++;
    if (Err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got=%b required=0", Err);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_mul;
    int stale;
    drive_op(8'd13, 8'd11, 6'b011000);
    idle(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || Result !== 8'h00 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_mul_reset got=vld%b res=%h rdy%b required=vld0 res=00 rdy0",
               out_valid, Result, in_ready);
    end
    rst_n = 1'b1;
    stale = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL stale_mul_output got=%0d_cycles_valid required=0", stale);
    end
    @(posedge clk); #1;
    sb.push_back({8'h07, 5'b00000});
    drive_op(8'h03, 8'h04, 6'b100000);
    total++;
    if (out_valid !== 1'b1 || Result !== 8'h07) begin
      bad++;
      $display("FAIL add_after_reset got=vld%b res=%h required=vld1 res=07", out_valid, Result);
    end
    idle(2);
  endtask

  task automatic test_random;
    logic [5:0] ops[12] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b000000, 6'b000010, 6'b000011, 6'b101010,
                            6'b011000, 6'b010101};
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a, b;
      logic [5:0] op;
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ops[$urandom_range(0, 11)];
      sb.push_back(model(a, b, op));
      drive_op(a, b, op);
    end
    for (int n = 0; n < 30 && sb.size() != 0; n++) idle(1);
    idle(1);
  endtask

  initial begin
    test_reset();
    test_add_sub_back_to_back();
    test_mul();
    test_shifts_slt();
    test_backpressure();
    test_invalid_opcode();
    test_reset_mid_mul();
    test_random();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d_pending required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
